// File: rtl/mips8_controller_if.sv
// Control bundle between the mips8 multicycle controller and its datapath:
// instruction fields and ALU zero flag in, every datapath control strobe out.
interface mips8_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memwrite;
    logic       pcen;
    logic       iord;
    logic       alusrcA;
    logic [1:0] alusrcB;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] irwrite;
    logic       illegal;

    // Datapath side: supplies instruction fields and zero, consumes controls.
    modport master (
        output op, funct, zero,
        input  memwrite, pcen, iord, alusrcA, alusrcB, memtoreg, regdst,
               regwrite, pcsrc, alucontrol, irwrite, illegal
    );

    // Controller side.
    modport slave (
        input  op, funct, zero,
        output memwrite, pcen, iord, alusrcA, alusrcB, memtoreg, regdst,
               regwrite, pcsrc, alucontrol, irwrite, illegal
    );
endinterface

// File: rtl/mips8_controller.sv
// Moore multicycle controller for the 8-bit MIPS datapath (byte-wide fetch).
// Optional MIPS8_CTRL_ILLEGAL_TRAP_EN: unknown opcodes halt and raise a sticky illegal flag.
module mips8_controller (
    input  logic                      clk,
    input  logic                      reset,
    mips8_controller_if.slave         bus,
    output logic [3:0]                debug_state
);
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, FETCH4, DECODE,
        MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, JEX, ADDIEX, ADDIWB
`ifdef MIPS8_CTRL_ILLEGAL_TRAP_EN
        , HALT
`endif
    } state_t;

    state_t     state_q, state_d;
    logic       mem_store_q;
    logic       pcwrite, branch;
    logic       memwrite_c, iord_c, alusrca_c, memtoreg_c, regdst_c, regwrite_c;
    logic [1:0] alusrcb_c, pcsrc_c;
    logic [2:0] alucontrol_c;
    logic [3:0] irwrite_c;

    // Load/store choice is latched in DECODE so op is never consulted in MEMADR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH1;
            mem_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) mem_store_q <= (bus.op == OP_SB);
        end
    end

    always_comb begin
        state_d      = state_q;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        memwrite_c   = 1'b0;
        iord_c       = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        memtoreg_c   = 1'b0;
        regdst_c     = 1'b0;
        regwrite_c   = 1'b0;
        pcsrc_c      = 2'b00;
        alucontrol_c = 3'b000;
        irwrite_c    = 4'b0000;
        case (state_q)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                alusrcb_c    = 2'b01;
                alucontrol_c = 3'b010;
                pcwrite      = 1'b1;
                case (state_q)
                    FETCH1:  begin irwrite_c = 4'b0001; state_d = FETCH2; end
                    FETCH2:  begin irwrite_c = 4'b0010; state_d = FETCH3; end
                    FETCH3:  begin irwrite_c = 4'b0100; state_d = FETCH4; end
                    default: begin irwrite_c = 4'b1000; state_d = DECODE; end
                endcase
            end
            DECODE: begin
                alusrcb_c    = 2'b11;
                alucontrol_c = 3'b010;
                case (bus.op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
`ifdef MIPS8_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = HALT;
`else
                    default:      state_d = FETCH1;
`endif
                endcase
            end
            MEMADR: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = 2'b10;
                alucontrol_c = 3'b010;
                state_d      = mem_store_q ? MEMWR : MEMRD;
            end
            MEMRD: begin iord_c = 1'b1; state_d = MEMWB; end
            MEMWB: begin memtoreg_c = 1'b1; regwrite_c = 1'b1; state_d = FETCH1; end
            MEMWR: begin iord_c = 1'b1; memwrite_c = 1'b1; state_d = FETCH1; end
            RTYPEEX: begin
                alusrca_c = 1'b1;
                case (bus.funct)
                    6'b100010: alucontrol_c = 3'b110;
                    6'b100100: alucontrol_c = 3'b000;
                    6'b100101: alucontrol_c = 3'b001;
                    6'b101010: alucontrol_c = 3'b111;
                    default:   alucontrol_c = 3'b010;
                endcase
                state_d = RTYPEWB;
            end
            RTYPEWB: begin regdst_c = 1'b1; regwrite_c = 1'b1; state_d = FETCH1; end
            BEQEX: begin
                alusrca_c    = 1'b1;
                alucontrol_c = 3'b110;
                pcsrc_c      = 2'b01;
                branch       = 1'b1;
                state_d      = FETCH1;
            end
            JEX: begin pcsrc_c = 2'b10; pcwrite = 1'b1; state_d = FETCH1; end
            ADDIEX: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = 2'b10;
                alucontrol_c = 3'b010;
                state_d      = ADDIWB;
            end
            ADDIWB: begin regwrite_c = 1'b1; state_d = FETCH1; end
`ifdef MIPS8_CTRL_ILLEGAL_TRAP_EN
            HALT: state_d = HALT;
`endif
            default: state_d = FETCH1;
        endcase
    end

`ifdef MIPS8_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 illegal_q <= 1'b0;
        else if (state_d == HALT)   illegal_q <= 1'b1;
    end
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    // Reset masks every strobe combinationally so an abort cannot leak a write.
    assign bus.memwrite   = reset & memwrite_c;
    assign bus.pcen       = reset & (pcwrite | (branch & bus.zero));
    assign bus.iord       = reset & iord_c;
    assign bus.alusrcA    = reset & alusrca_c;
    assign bus.alusrcB    = reset ? alusrcb_c : 2'b00;
    assign bus.memtoreg   = reset & memtoreg_c;
    assign bus.regdst     = reset & regdst_c;
    assign bus.regwrite   = reset & regwrite_c;
    assign bus.pcsrc      = reset ? pcsrc_c : 2'b00;
    assign bus.alucontrol = reset ? alucontrol_c : 3'b000;
    assign bus.irwrite    = reset ? irwrite_c : 4'b0000;
    assign debug_state    = state_q;
endmodule

// File: tb/tb_mips8_controller.sv
// Bench for mips8_controller: per-instruction cycle model, vector table, random
// instruction stream, reset abort and illegal-opcode sequences.
module tb_mips8_controller;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] debug_state;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [18:0] exp_q[$];
    logic [18:0] seen[1:8];

    always #5 clk = ~clk;

    mips8_controller_if bus();
    mips8_controller dut (.clk(clk), .reset(reset), .bus(bus), .debug_state(debug_state));

    // {memwrite,pcen,iord,alusrcA,alusrcB,memtoreg,regdst,regwrite,pcsrc,alucontrol,irwrite,illegal}
    logic [18:0] got;
    assign got = {bus.memwrite, bus.pcen, bus.iord, bus.alusrcA, bus.alusrcB, bus.memtoreg,
                  bus.regdst, bus.regwrite, bus.pcsrc, bus.alucontrol, bus.irwrite, bus.illegal};

    function automatic logic [18:0] mk(input logic mw, input logic pcen, input logic iord,
                                       input logic asa, input logic [1:0] asb, input logic m2r,
                                       input logic rd, input logic rw, input logic [1:0] ps,
                                       input logic [2:0] alu, input logic [3:0] ir, input logic ill);
        return {mw, pcen, iord, asa, asb, m2r, rd, rw, ps, alu, ir, ill};
    endfunction

    function automatic int latency(input logic [5:0] op);
        case (op)
            OP_LB:                     return 8;
            OP_SB, OP_RTYPE, OP_ADDI:  return 7;
            OP_BEQ, OP_J:              return 6;
            default:                   return 5;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected controls for cycle c (1-based) of one instruction.
    function automatic logic [18:0] expect_cycle(input logic [5:0] op, input logic [5:0] funct,
                                                 input logic zero, input int c);
        logic [3:0] ir;
        ir = 4'b0001;
        ir = ir << (c - 1);
        if (c <= 4) return mk(0, 1, 0, 0, 2'b01, 0, 0, 0, 2'b00, 3'b010, ir, 0);
        if (c == 5) return mk(0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b00, 3'b010, 4'b0, 0);
        case (op)
            OP_LB, OP_SB: begin
                if (c == 6) return mk(0, 0, 0, 1, 2'b10, 0, 0, 0, 2'b00, 3'b010, 4'b0, 0);
                if (op == OP_SB) return mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 3'b000, 4'b0, 0);
                if (c == 7) return mk(0, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 3'b000, 4'b0, 0);
                return mk(0, 0, 0, 0, 2'b00, 1, 0, 1, 2'b00, 3'b000, 4'b0, 0);
            end
            OP_RTYPE: begin
                if (c == 6) return mk(0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00, funct_alu(funct), 4'b0, 0);
                return mk(0, 0, 0, 0, 2'b00, 0, 1, 1, 2'b00, 3'b000, 4'b0, 0);
            end
            OP_BEQ:  return mk(0, zero, 0, 1, 2'b00, 0, 0, 0, 2'b01, 3'b110, 4'b0, 0);
            OP_J:    return mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b10, 3'b000, 4'b0, 0);
            OP_ADDI: begin
                if (c == 6) return mk(0, 0, 0, 1, 2'b10, 0, 0, 0, 2'b00, 3'b010, 4'b0, 0);
                return mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 3'b000, 4'b0, 0);
            end
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [18:0] actual, input logic [18:0] required);
        n_cmp++;
        if (actual !== required) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, actual, required);
        end
    endtask

    // Runs one instruction starting in a FETCH1 cycle at posedge+1. Inputs that the
    // controller must ignore are randomised. upto>0 stops after that cycle without advancing.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                             input int upto, input string tag);
        int n;
        logic [18:0] e;
        n = latency(op);
        if (upto > 0 && upto < n) n = upto;
        for (int c = 1; c <= n; c++) exp_q.push_back(expect_cycle(op, funct, zero, c));
        for (int c = 1; c <= n; c++) begin
            bus.op    = (c == 5) ? op : 6'($urandom_range(63, 0));
            bus.funct = (c == 6 && op == OP_RTYPE) ? funct : 6'($urandom_range(63, 0));
            bus.zero  = (c == 6) ? zero : 1'($urandom_range(1, 0));
            #1;
            e = exp_q.pop_front();
            seen[c] = got;
            check($sformatf("%s c%0d", tag, c), got, e);
            if (upto == 0 || c < n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return op == OP_LB || op == OP_SB || op == OP_RTYPE || op == OP_BEQ ||
               op == OP_J || op == OP_ADDI;
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          key_cycle;
        logic [18:0] key_exp;
        string       tag;
    } vec_t;
    vec_t tbl[$];

    initial begin
        logic [5:0] rop;
        logic [5:0] ops[6];

        tbl.push_back('{OP_ADDI,  6'b000000, 1'b0, 7, mk(0,0,0,0,2'b00,0,0,1,2'b00,3'b000,4'b0,0), "addi"});
        tbl.push_back('{OP_BEQ,   6'b000000, 1'b1, 6, mk(0,1,0,1,2'b00,0,0,0,2'b01,3'b110,4'b0,0), "beq_z1"});
        tbl.push_back('{OP_BEQ,   6'b000000, 1'b0, 6, mk(0,0,0,1,2'b00,0,0,0,2'b01,3'b110,4'b0,0), "beq_z0"});
        tbl.push_back('{OP_LB,    6'b000000, 1'b0, 8, mk(0,0,0,0,2'b00,1,0,1,2'b00,3'b000,4'b0,0), "lb"});
        tbl.push_back('{OP_SB,    6'b000000, 1'b0, 7, mk(1,0,1,0,2'b00,0,0,0,2'b00,3'b000,4'b0,0), "sb"});
        tbl.push_back('{OP_RTYPE, 6'b100000, 1'b0, 6, mk(0,0,0,1,2'b00,0,0,0,2'b00,3'b010,4'b0,0), "r_add"});
        tbl.push_back('{OP_RTYPE, 6'b100010, 1'b0, 6, mk(0,0,0,1,2'b00,0,0,0,2'b00,3'b110,4'b0,0), "r_sub"});
        tbl.push_back('{OP_RTYPE, 6'b100100, 1'b0, 6, mk(0,0,0,1,2'b00,0,0,0,2'b00,3'b000,4'b0,0), "r_and"});
        tbl.push_back('{OP_RTYPE, 6'b100101, 1'b0, 6, mk(0,0,0,1,2'b00,0,0,0,2'b00,3'b001,4'b0,0), "r_or"});
        tbl.push_back('{OP_RTYPE, 6'b101010, 1'b0, 6, mk(0,0,0,1,2'b00,0,0,0,2'b00,3'b111,4'b0,0), "r_slt"});
        tbl.push_back('{OP_RTYPE, 6'b111111, 1'b1, 7, mk(0,0,0,0,2'b00,0,1,1,2'b00,3'b000,4'b0,0), "r_unk"});
        tbl.push_back('{OP_J,     6'b000000, 1'b0, 6, mk(0,1,0,0,2'b10,0,0,0,2'b10,3'b000,4'b0,0) & ~19'(1 << 14), "j"});
`ifndef MIPS8_CTRL_ILLEGAL_TRAP_EN
        tbl.push_back('{6'b111111, 6'b000000, 1'b0, 5, mk(0,0,0,0,2'b11,0,0,0,2'b00,3'b010,4'b0,0), "nop_ill"});
`endif

        // Reset held three cycles: every output low.
        reset = 1'b0;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            bus.op = 6'($urandom_range(63, 0));
            bus.zero = 1'($urandom_range(1, 0));
            #2;
            check($sformatf("reset c%0d", i), got, '0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, 0, tbl[i].tag);
            check($sformatf("%s key", tbl[i].tag), seen[tbl[i].key_cycle], tbl[i].key_exp);
        end

        ops = '{OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};
        for (int i = 0; i < 60; i++) begin
            rop = ops[$urandom_range(5, 0)];
`ifndef MIPS8_CTRL_ILLEGAL_TRAP_EN
            if ($urandom_range(7, 0) == 0) begin
                rop = 6'($urandom_range(63, 0));
                for (int k = 0; k < 64 && is_legal(rop); k++) rop = rop + 6'd1;
            end
`endif
            run_instr(rop, 6'($urandom_range(63, 0)), 1'($urandom_range(1, 0)), 0,
                      $sformatf("rnd%0d_op%b", i, rop));
        end

        // Reset pulsed while an LB sits in MEMRD: no writeback may follow.
        run_instr(OP_LB, 6'b0, 1'b0, 7, "lb_abort");
        reset = 1'b0;
        #1;
        check("abort_rst_now", got, '0);
        @(posedge clk);
        #2;
        check("abort_rst_edge", got, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(OP_ADDI, 6'b0, 1'b0, 0, "after_abort");

`ifdef MIPS8_CTRL_ILLEGAL_TRAP_EN
        run_instr(6'b111111, 6'b0, 1'b0, 0, "ill");
        for (int i = 0; i < 4; i++) begin
            bus.op = ops[$urandom_range(5, 0)];
            bus.zero = 1'($urandom_range(1, 0));
            #1;
            check($sformatf("halt c%0d", i), got, mk(0,0,0,0,2'b00,0,0,0,2'b00,3'b000,4'b0,1));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        check("halt_rst", got, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(OP_J, 6'b0, 1'b0, 0, "after_halt");
`else
        run_instr(6'b111111, 6'b0, 1'b0, 0, "ill_nop");
        run_instr(OP_BEQ, 6'b0, 1'b1, 0, "after_ill");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
